// File: rtl/hazard_pkg.sv
// ============================================================================
// Module : hazard_pkg
// Brief  : Shared types and constants for the hazard detection unit.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hazard_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  localparam logic [1:0] REGWRITE_NONE         = 2'b00;
  localparam int         MULDIV_CYCLES_DEFAULT = 4;

endpackage

`default_nettype wire

// File: rtl/muldiv_stall_fsm.sv
// ============================================================================
// Module : muldiv_stall_fsm
// Brief  : Holds EX while a multi-cycle MUL/DIV occupies it.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_stall_fsm
  import hazard_pkg::*;
#(
  parameter int MULDIV_CYCLES = MULDIV_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ex_is_muldiv,
  output logic md_hold
);

  localparam int                 c_cnt_w    = ($clog2(MULDIV_CYCLES) > 0) ? $clog2(MULDIV_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(MULDIV_CYCLES - 2);

  md_state_t          r_state;
  logic [c_cnt_w-1:0] r_md_cnt;

  // The trigger cycle is itself a hold cycle, so the counter only covers
  // the remaining MULDIV_CYCLES-2 holds before the release cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_md_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (ex_is_muldiv) begin
            r_state  <= MD_BUSY;
            r_md_cnt <= c_cnt_init;
          end
        end
        MD_BUSY: begin
          if (r_md_cnt != '0) begin
            r_md_cnt <= r_md_cnt - 1'b1;
          end else begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_md_cnt <= '0;
        end
      endcase
    end
  end

  assign md_hold = ((r_state == IDLE) & ex_is_muldiv) |
                   ((r_state == MD_BUSY) & (r_md_cnt != '0));

endmodule

`default_nettype wire

// File: rtl/hazard_detection_unit.sv
// ============================================================================
// Module : hazard_detection_unit
// Brief  : Stall / bubble / flush control for hazards forwarding cannot cover.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_detection_unit
  import hazard_pkg::*;
#(
  parameter int MULDIV_CYCLES = MULDIV_CYCLES_DEFAULT,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       id_op1,
  input  logic [3:0]       id_op2,
  input  logic             id_uses_op2,
  input  logic             id_is_branch,
  input  logic             id_branch_taken,
  input  logic [3:0]       ex_op1,
  input  logic [1:0]       ex_regwrite,
  input  logic             ex_memread,
  input  logic             ex_is_muldiv,
  input  logic [3:0]       mem_op1,
  input  logic             mem_memread,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             ex_hold,
  output logic             exmem_flush,
  output logic [CNT_W-1:0] stall_count
);

  logic             w_md_hold;
  logic             w_ex_writes;
  logic             w_lu;
  logic             w_bd;
  logic [CNT_W-1:0] r_stall_count;

  muldiv_stall_fsm #(
    .MULDIV_CYCLES(MULDIV_CYCLES)
  ) u_muldiv_stall_fsm (
    .clk         (clk),
    .rst_n       (rst_n),
    .ex_is_muldiv(ex_is_muldiv),
    .md_hold     (w_md_hold)
  );

  assign w_ex_writes = (ex_regwrite != REGWRITE_NONE);

  assign w_lu = ex_memread & w_ex_writes &
                ((ex_op1 == id_op1) | (id_uses_op2 & (ex_op1 == id_op2)));

  // Branches compare in ID, so any producer still in EX, or a load still in
  // MEM, has no value available to forward yet.
  assign w_bd = id_is_branch &
                ((w_ex_writes & (ex_op1 == id_op1)) |
                 (mem_memread & (mem_op1 == id_op1)));

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    ex_hold     = 1'b0;
    exmem_flush = 1'b0;
    if (!rst_n) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (w_md_hold) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ex_hold     = 1'b1;
      exmem_flush = 1'b1;
    end else if (w_lu | w_bd) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_flush  = 1'b1;
    end else if (id_is_branch & id_branch_taken) begin
      ifid_flush  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_count <= '0;
    end else if (!pc_write && (r_stall_count != '1)) begin
      r_stall_count <= r_stall_count + 1'b1;
    end
  end

  assign stall_count = r_stall_count;

endmodule

`default_nettype wire

// File: tb/tb_hazard_detection_unit.sv
// ============================================================================
// Module : tb_hazard_detection_unit
// Brief  : Scoreboard bench for hazard_detection_unit (4- and 2-cycle MUL/DIV).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_detection_unit;

  typedef struct packed {
    logic [3:0] id_op1;
    logic [3:0] id_op2;
    logic       id_uses_op2;
    logic       id_is_branch;
    logic       id_branch_taken;
    logic [3:0] ex_op1;
    logic [1:0] ex_regwrite;
    logic       ex_memread;
    logic       ex_is_muldiv;
    logic [3:0] mem_op1;
    logic       mem_memread;
  } in_t;

  typedef struct {
    bit          sel;
    logic [5:0]  outs;
    logic [15:0] cnt;
    string       name;
  } exp_t;

  // {pc_write, ifid_write, ifid_flush, idex_flush, ex_hold, exmem_flush}
  localparam logic [5:0] c_norm  = 6'b110000;
  localparam logic [5:0] c_stall = 6'b000100;
  localparam logic [5:0] c_md    = 6'b000011;
  localparam logic [5:0] c_brf   = 6'b111000;
  localparam logic [5:0] c_rst   = 6'b001101;

  logic        clk = 1'b0;
  logic        rst_n;
  in_t         ia;
  in_t         ib;
  in_t         v;
  logic [5:0]  out_a;
  logic [5:0]  out_b;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;
  logic [15:0] mcnt_a;
  logic [15:0] mcnt_b;
  exp_t        sb_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  logic pc_write_a, ifid_write_a, ifid_flush_a, idex_flush_a, ex_hold_a, exmem_flush_a;
  logic pc_write_b, ifid_write_b, ifid_flush_b, idex_flush_b, ex_hold_b, exmem_flush_b;

  always #5 clk = ~clk;

  hazard_detection_unit #(.MULDIV_CYCLES(4), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .id_op1(ia.id_op1), .id_op2(ia.id_op2), .id_uses_op2(ia.id_uses_op2),
    .id_is_branch(ia.id_is_branch), .id_branch_taken(ia.id_branch_taken),
    .ex_op1(ia.ex_op1), .ex_regwrite(ia.ex_regwrite), .ex_memread(ia.ex_memread),
    .ex_is_muldiv(ia.ex_is_muldiv), .mem_op1(ia.mem_op1), .mem_memread(ia.mem_memread),
    .pc_write(pc_write_a), .ifid_write(ifid_write_a), .ifid_flush(ifid_flush_a),
    .idex_flush(idex_flush_a), .ex_hold(ex_hold_a), .exmem_flush(exmem_flush_a),
    .stall_count(cnt_a)
  );

  hazard_detection_unit #(.MULDIV_CYCLES(2), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .id_op1(ib.id_op1), .id_op2(ib.id_op2), .id_uses_op2(ib.id_uses_op2),
    .id_is_branch(ib.id_is_branch), .id_branch_taken(ib.id_branch_taken),
    .ex_op1(ib.ex_op1), .ex_regwrite(ib.ex_regwrite), .ex_memread(ib.ex_memread),
    .ex_is_muldiv(ib.ex_is_muldiv), .mem_op1(ib.mem_op1), .mem_memread(ib.mem_memread),
    .pc_write(pc_write_b), .ifid_write(ifid_write_b), .ifid_flush(ifid_flush_b),
    .idex_flush(idex_flush_b), .ex_hold(ex_hold_b), .exmem_flush(exmem_flush_b),
    .stall_count(cnt_b)
  );

  assign out_a = {pc_write_a, ifid_write_a, ifid_flush_a, idex_flush_a, ex_hold_a, exmem_flush_a};
  assign out_b = {pc_write_b, ifid_write_b, ifid_flush_b, idex_flush_b, ex_hold_b, exmem_flush_b};

  // Drive one cycle of inputs into the selected DUT (the other idles) and
  // queue the hand-computed response for that cycle.
  task automatic step(input bit sel, input logic rst, input in_t in,
                      input logic [5:0] exp, input string name);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rst;
    if (sel) begin
      ib = in;
      ia = '0;
    end else begin
      ia = in;
      ib = '0;
    end
    if (!rst) begin
      mcnt_a = '0;
      mcnt_b = '0;
    end
    e.sel  = sel;
    e.outs = exp;
    e.cnt  = sel ? mcnt_b : mcnt_a;
    e.name = name;
    sb_q.push_back(e);
    if (rst && !exp[5]) begin
      if (sel) mcnt_b = (mcnt_b == 16'd3) ? 16'd3 : mcnt_b + 16'd1;
      else     mcnt_a = (mcnt_a == 16'hFFFF) ? 16'hFFFF : mcnt_a + 16'd1;
    end
  endtask

  always @(negedge clk) begin
    exp_t        e;
    logic [5:0]  got;
    logic [15:0] gcnt;
    while (sb_q.size() > 0) begin
      e    = sb_q.pop_front();
      got  = e.sel ? out_b : out_a;
      gcnt = e.sel ? {14'b0, cnt_b} : cnt_a;
      n_tests++;
      if (got !== e.outs) begin
        n_fail++;
        $display("FAIL %s: outputs got %b required %b", e.name, got, e.outs);
      end
      n_tests++;
      if (gcnt !== e.cnt) begin
        n_fail++;
        $display("FAIL %s_count: stall_count got %0d required %0d", e.name, gcnt, e.cnt);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n  = 1'b0;
    ia     = '0;
    ib     = '0;
    mcnt_a = '0;
    mcnt_b = '0;

    v = '0;
    step(0, 0, v, c_rst, "reset_a");
    step(1, 0, v, c_rst, "reset_b");
    step(0, 1, v, c_norm, "idle_after_reset");

    // load-use
    v = '0; v.ex_memread = 1; v.ex_regwrite = 2'b01; v.ex_op1 = 4'h3; v.id_op1 = 4'h3;
    step(0, 1, v, c_stall, "lu_op1");
    v = '0;
    step(0, 1, v, c_norm, "lu_release");
    v = '0; v.ex_memread = 1; v.ex_regwrite = 2'b10; v.ex_op1 = 4'h3;
    v.id_op1 = 4'h1; v.id_op2 = 4'h3; v.id_uses_op2 = 1;
    step(0, 1, v, c_stall, "lu_op2");
    v.id_uses_op2 = 0;
    step(0, 1, v, c_norm, "lu_op2_unused");
    v.id_op1 = 4'h3; v.ex_regwrite = 2'b00;
    step(0, 1, v, c_norm, "lu_no_regwrite");
    v.ex_regwrite = 2'b11; v.ex_op1 = 4'h0; v.id_op1 = 4'h0;
    step(0, 1, v, c_stall, "lu_r0");

    // branch after load: two stalls, then the taken branch flushes IF/ID
    v = '0; v.id_is_branch = 1; v.id_branch_taken = 1; v.id_op1 = 4'h5;
    v.ex_memread = 1; v.ex_regwrite = 2'b01; v.ex_op1 = 4'h5;
    step(0, 1, v, c_stall, "bl_ex");
    v = '0; v.id_is_branch = 1; v.id_branch_taken = 1; v.id_op1 = 4'h5;
    v.mem_memread = 1; v.mem_op1 = 4'h5;
    step(0, 1, v, c_stall, "bl_mem");
    v.mem_memread = 0;
    step(0, 1, v, c_brf, "bl_resolved");
    v = '0;
    step(0, 1, v, c_norm, "bl_idle");

    // branch after ALU op: one stall, then forwarded from MEM
    v = '0; v.id_is_branch = 1; v.id_op1 = 4'h7; v.ex_regwrite = 2'b01; v.ex_op1 = 4'h7;
    step(0, 1, v, c_stall, "ba_ex");
    v = '0; v.id_is_branch = 1; v.id_op1 = 4'h7; v.mem_op1 = 4'h7;
    step(0, 1, v, c_norm, "ba_fwd");

    // taken branch without hazard, and a taken flag on a non-branch
    v = '0; v.id_is_branch = 1; v.id_branch_taken = 1; v.id_op1 = 4'h9;
    v.ex_regwrite = 2'b01; v.ex_op1 = 4'h2;
    step(0, 1, v, c_brf, "br_taken");
    v = '0; v.id_branch_taken = 1;
    step(0, 1, v, c_norm, "taken_not_branch");

    // 4-cycle MUL/DIV: 3 holds, release with ex_is_muldiv still high
    v = '0; v.ex_is_muldiv = 1;
    step(0, 1, v, c_md, "md_hold1");
    step(0, 1, v, c_md, "md_hold2");
    step(0, 1, v, c_md, "md_hold3");
    step(0, 1, v, c_norm, "md_release");
    v = '0;
    step(0, 1, v, c_norm, "md_after");

    // MUL/DIV hold masks a simultaneous load-use and taken branch
    v = '0; v.ex_is_muldiv = 1; v.ex_memread = 1; v.ex_regwrite = 2'b01; v.ex_op1 = 4'h4;
    v.id_op1 = 4'h4; v.id_is_branch = 1; v.id_branch_taken = 1;
    step(0, 1, v, c_md, "sim_md1");
    step(0, 1, v, c_md, "sim_md2");
    step(0, 1, v, c_md, "sim_md3");
    step(0, 1, v, c_stall, "sim_release");
    v = '0;
    step(0, 1, v, c_norm, "sim_idle");

    // reset in the middle of a MUL/DIV
    v = '0; v.ex_is_muldiv = 1;
    step(0, 1, v, c_md, "rm_hold1");
    step(0, 1, v, c_md, "rm_hold2");
    step(0, 0, v, c_rst, "rst_mid");
    v = '0;
    step(0, 1, v, c_norm, "rst_release");
    step(0, 1, v, c_norm, "rst_idle");

    // 2-cycle MUL/DIV instance with a 2-bit counter
    v = '0; v.ex_is_muldiv = 1;
    step(1, 1, v, c_md, "b_md_hold");
    step(1, 1, v, c_norm, "b_md_release");
    v = '0;
    step(1, 1, v, c_norm, "b_idle");
    v = '0; v.ex_memread = 1; v.ex_regwrite = 2'b01; v.ex_op1 = 4'hA; v.id_op1 = 4'hA;
    step(1, 1, v, c_stall, "b_sat1");
    step(1, 1, v, c_stall, "b_sat2");
    step(1, 1, v, c_stall, "b_sat3");
    step(1, 1, v, c_stall, "b_sat4");
    v = '0;
    step(1, 1, v, c_norm, "b_sat_hold");

    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, required 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
